// File: rtl/uart_txstr_pkg.sv
// uart_txstr_pkg: shared constants and types for the UART string transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: baud divisors for a 12 MHz clock, FSM state encoding, counter-width helper.
package uart_txstr_pkg;

  // Clock cycles per bit at 12 MHz for common baud rates.
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_txstr_if.sv
// uart_txstr_if: control/status bundle between a driver and the string transmitter.
// Latency: n/a (wires only).
// Backpressure: none; start is dropped by the transmitter while busy.
// Signals: start, mode (driver -> transmitter); tx, busy, done, char_idx (transmitter -> driver).
interface uart_txstr_if #(
  parameter int MSG_LEN = 4
) ();
  import uart_txstr_pkg::*;

  localparam int IDX_W = cnt_w(MSG_LEN);

  logic             start;
  logic             mode;
  logic             tx;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] char_idx;

  modport master (
    output start, mode,
    input  tx, busy, done, char_idx
  );

  modport slave (
    input  start, mode,
    output tx, busy, done, char_idx
  );

endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serialiser, LSB first, every bit held for BAUDDIV cycles.
// Latency: tx drops to the start bit on the edge that accepts load; frame_done is high in the last stop-bit cycle.
// Backpressure: load is honoured only while ready=1; a load while a frame is in flight is dropped.
// Ports: clk, rstn (async, active low), data[7:0], load in; tx, ready, frame_done out.
module uart_tx_core #(
  parameter int BAUDDIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       ready,
  output logic       frame_done
);
  localparam int             BW       = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;
  localparam logic [BW-1:0]  BAUD_MAX = BW'(BAUDDIV - 1);

  logic          active_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;    // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          baud_wrap;

  assign baud_wrap  = active_q && (baud_q == BAUD_MAX);
  // Combinational so the controller can reload during the final stop cycle,
  // leaving a single idle cycle between back-to-back frames.
  assign frame_done = baud_wrap && (bit_q == 4'd9);
  assign ready      = !active_q;
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else if (load && !active_q) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= data;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (baud_wrap) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            tx_q <= 1'b1;   // entering the stop bit
          end
        end
      end else begin
        baud_q <= baud_q + BW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_txstr.sv
// uart_txstr: sends the packed MSG string as 8N1 frames, one-shot on start or repeating in continuous mode.
// Latency: start seen at edge k -> busy from k+1 -> start bit from k+2; 1 idle cycle between characters, GAP_CYCLES+2 between messages.
// Backpressure: none upstream; start is ignored while busy, the serialiser is loaded only when ready.
// Ports: clk, rstn (async, active low); bus (slave): start, mode in; tx, busy, done, char_idx out.
module uart_txstr
  import uart_txstr_pkg::*;
#(
  parameter int                   BAUDDIV    = 104,
  parameter int                   MSG_LEN    = 4,
  parameter logic [8*MSG_LEN-1:0] MSG        = "HOLA",
  parameter int                   GAP_CYCLES = 0
) (
  input logic         clk,
  input logic         rstn,
  uart_txstr_if.slave bus
);
  localparam int               IDX_W    = cnt_w(MSG_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
  localparam int               GW       = cnt_w(GAP_CYCLES + 1);
  localparam logic [GW-1:0]    GAP_MAX  = GW'(GAP_CYCLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   char_idx_q, char_idx_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic               done_q, done_d;
  logic               start_q;

  logic               core_load;
  logic               core_ready;
  logic               core_frame_done;
  logic [7:0]         char_dat;
  logic [8*MSG_LEN-1:0] msg_sh;

  // Character 0 lives in the MSBs: shift the wanted byte down to [7:0].
  always_comb begin
    msg_sh = MSG >> (8 * (MSG_LEN - 1 - int'(char_idx_q)));
  end
  assign char_dat = msg_sh[7:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      char_idx_q <= '0;
      gap_cnt_q  <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
      // Registered so the board-level start pin never feeds the FSM directly;
      // this flop is the extra cycle between start and busy.
      start_q    <= bus.start;
    end
  end

  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    core_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_q || bus.mode) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        core_load = core_ready;
        if (core_ready) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (core_frame_done) begin
          if (char_idx_q != IDX_LAST) begin
            char_idx_d = char_idx_q + IDX_W'(1);
            state_d    = ST_LOAD;
          end else begin
            // done registers here so it lands in the first cycle after the stop bit.
            done_d     = 1'b1;
            char_idx_d = '0;
            gap_cnt_d  = '0;
            state_d    = bus.mode ? ST_GAP : ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // GAP_CYCLES+1 cycles here plus the LOAD cycle give GAP_CYCLES+2 idle bits.
        if (gap_cnt_q == GAP_MAX) state_d = ST_LOAD;
        else                      gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_core #(
    .BAUDDIV (BAUDDIV)
  ) u_core (
    .clk        (clk),
    .rstn       (rstn),
    .data       (char_dat),
    .load       (core_load),
    .tx         (bus.tx),
    .ready      (core_ready),
    .frame_done (core_frame_done)
  );

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.char_idx = char_idx_q;

endmodule

// File: doc/uart_txstr.md
Name: uart_txstr

Overview:
- Parametrised UART string transmitter. Sends a fixed multi-character message from a packed parameter string as 8N1 frames.
- Two modes, selected at runtime: one-shot on a start pulse, or continuous repetition with a programmable inter-message gap.
- Next generation of the fixed-character continuous-transmit example. Intended as a board-level test/banner source driving the FPGA tx pin.
- Contains its own 8N1 serialiser sub-module.

Parameters:
- BAUDDIV, 104: clock cycles per serial bit. 104 gives 115200 baud at 12 MHz. Minimum 2.
- MSG_LEN, 4: number of characters in the message. Minimum 1.
- MSG, "HOLA": packed message, 8*MSG_LEN bits. Leftmost character sits in the MSBs.
- GAP_CYCLES, 0: extra idle cycles between messages in continuous mode. 0 is legal.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous reset, active low
- start  in  1  level/pulse; sampled only in IDLE; starts one message
- mode  in  1  0 = one-shot, 1 = continuous
- tx  out  1  serial data; idle high
- busy  out  1  high from message start until return to IDLE
- done  out  1  one-cycle pulse at the end of every message
- char_idx  out  $clog2(MSG_LEN) (min 1)  index of the character currently being framed

Behaviour:
- Reset (rstn=0, asynchronous): all state is cleared. Outputs: tx=1, busy=0, done=0, char_idx=0, FSM=IDLE, serialiser idle. A reset mid-frame forces tx high immediately; no partial frame resumes after reset.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BAUDDIV cycles, so a frame is 10*BAUDDIV cycles.
- Character order: char 0 = MSG[8*MSG_LEN-1 -: 8], char i = MSG[8*(MSG_LEN-i)-1 -: 8].
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE:
  - busy=0.
  - Exit to LOAD when start=1 at a rising edge, or when mode=1. In continuous mode, leaving reset starts transmission with no start pulse.
- LOAD:
  - Presents char[char_idx] to the serialiser with a one-cycle load strobe. Next state is SEND.
- SEND:
  - Waits for the serialiser's frame-complete strobe.
  - If char_idx < MSG_LEN-1: increment char_idx and go to LOAD.
  - Otherwise: pulse done, clear char_idx to 0, and branch:
    - mode=1 → GAP;
    - mode=0 → IDLE.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to LOAD. busy stays 1.
  - When GAP_CYCLES=0, GAP lasts a single cycle.
- Latency:
  - start sampled at edge k → busy=1 from edge k+1 → tx falls (start bit) at edge k+2.
- Inter-character spacing: exactly 1 idle (high) cycle between a stop-bit end and the next start bit.
- Inter-message spacing (continuous): exactly GAP_CYCLES+2 idle cycles between the last stop-bit end and the next start bit.
- done: asserted on the cycle immediately after the last stop bit ends, in both modes.
- mode: sampled only at the end of a message (SEND→next) and in IDLE.
  - Switching 1→0 mid-message completes the current message, pulses done, then goes to IDLE.
  - Switching 0→1 during a one-shot message makes it repeat.
- start while busy=1 is ignored (no queueing). start held high in one-shot mode retriggers on the cycle after return to IDLE.
- Serialiser counters:
  - baud counter is $clog2(BAUDDIV) bits and wraps at BAUDDIV-1;
  - bit counter runs 0..9;
  - char_idx wraps from MSG_LEN-1 to 0 only via the end-of-message path.

Decomposition:
- Shared package/header holds:
  - baud divisor constants (B115200=104, B57600=208, B38400=313, B19200=625, B9600=1250 at 12 MHz);
  - FSM state encodings.
- One sub-module: uart_tx_core.
  - Function: 8N1 shifter with a baud counter.
  - Ports: clk, rstn, data[7:0], load, tx, ready, frame_done.
  - Accepts load only when ready=1.

Test Plan (BAUDDIV=4, MSG="AB", MSG_LEN=2 unless noted):
1. Reset: hold rstn=0 for 5 cycles with start=1, mode=0 → tx=1, busy=0, done=0, char_idx=0 throughout.
2. One-shot, mode=0, start pulse at edge k:
   - tx falls at k+2;
   - bits 0,1,0,0,0,0,0,1,0,1 for 0x41, each 4 cycles;
   - 1 idle cycle;
   - 0x42 frame;
   - done=1 for exactly one cycle after the second stop bit; busy=0 on the next cycle;
   - total of 2 frames.
3. Retrigger ignored: second start pulse during the 0x41 frame → exactly 2 frames, one done pulse.
4. Continuous, mode=1, GAP_CYCLES=10, no start → repeating A,B.
   - 12 idle cycles between each B stop bit and the next A start bit.
   - done pulses once per message.
   - busy is never 0 after the first load.
5. Reset mid-frame: drop rstn during data bit 3 of 0x42 → tx=1 within the same cycle.
   - After release with mode=0, nothing transmits until start.
6. Mode 1→0 during char A of a continuous message → B completes, done pulses, FSM returns to IDLE, tx stays high.
